fact_batch_master: RTL

Parametrised bus-master factorial engine and the successor to the single-shot factorial master. One start command processes a batch of jobs. For each job the engine reads N from memory over the shared master bus, computes N! iteratively at a configurable result width with overflow detection, and writes the result back as consecutive bus words. It sits beside the other bus masters behind the bus arbiter and is controlled directly by the host through start/clear pins.

---
 rtl/fact_pkg.sv | 24 ++
 rtl/fact_mul_unit.sv | 43 ++++
 rtl/fact_batch_master.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fact_pkg.sv
// Shared types and width rules for the batch factorial bus master.
package fact_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_RES_W  = 64;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_REQ  = 4'd1,
    ST_RD_DATA = 4'd2,
    ST_CALC    = 4'd3,
    ST_WR      = 4'd4,
    ST_NEXT    = 4'd5,
    ST_DONE    = 4'd6
  } state_t;

  // A result occupies this many consecutive bus words; RES_W must be a multiple of DATA_W.
  function automatic int words_of(input int res_w, input int data_w);
    return res_w / data_w;
  endfunction

endpackage

// File: rtl/fact_mul_unit.sv
// Iterative factorial datapath: acc *= cnt-- until cnt <= 1, with overflow flag on truncation.
module fact_mul_unit import fact_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RES_W  = DEF_RES_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_din,
  output logic [RES_W-1:0]  o_acc,
  output logic              o_busy,
  output logic              o_ovf
);

  logic [RES_W-1:0]        r_acc;
  logic [DATA_W-1:0]       r_cnt;
  logic [RES_W+DATA_W-1:0] w_prod;

  assign w_prod = {{DATA_W{1'b0}}, r_acc} * {{RES_W{1'b0}}, r_cnt};
  // Flag is only meaningful while stepping; the top qualifies it with i_step.
  assign o_ovf  = |w_prod[RES_W+DATA_W-1:RES_W];
  assign o_busy = r_cnt > DATA_W'(1);
  assign o_acc  = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= RES_W'(1);
      r_cnt <= i_din;
    end else if (i_step && o_busy) begin
      r_acc <= w_prod[RES_W-1:0];
      r_cnt <= r_cnt - DATA_W'(1);
    end
  end

endmodule

// File: rtl/fact_batch_master.sv
// Batch factorial bus master: reads N per job, computes N!, writes the result LSW first.
module fact_batch_master import fact_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RES_W  = DEF_RES_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic              op_clear,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  job_count,
  input  logic              M_grant,
  input  logic [DATA_W-1:0] M_din,
  output logic              M_req,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_address,
  output logic [DATA_W-1:0] M_dout,
  output logic [RES_W-1:0]  result,
  output logic              overflow,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  jobs_done,
  output logic [3:0]        state
);

  localparam int WORDS = words_of(RES_W, DATA_W);
  localparam int K_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t            r_state;
  logic              r_req, r_wr, r_ovf;
  logic [ADDR_W-1:0] r_addr, r_rd_addr, r_wbase;
  logic [DATA_W-1:0] r_dout;
  logic [RES_W-1:0]  r_result;
  logic [CNT_W-1:0]  r_jobs_done, r_count;
  logic [K_W-1:0]    r_k;
  logic [RES_W-1:0]  w_acc;
  logic              w_mul_busy, w_mul_ovf;

  function automatic logic [DATA_W-1:0] word_sel(input logic [RES_W-1:0] a, input logic [K_W-1:0] k);
    return DATA_W'(a >> (k * DATA_W));
  endfunction

  fact_mul_unit #(.DATA_W(DATA_W), .RES_W(RES_W)) u_mul (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_clear (op_clear),
    .i_load  (r_state == ST_RD_DATA),
    .i_step  (r_state == ST_CALC),
    .i_din   (M_din),
    .o_acc   (w_acc),
    .o_busy  (w_mul_busy),
    .o_ovf   (w_mul_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_dout      <= '0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_jobs_done <= '0;
      r_count     <= '0;
      r_rd_addr   <= '0;
      r_wbase     <= '0;
      r_k         <= '0;
    end else if (op_clear) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_wr        <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_jobs_done <= '0;
      r_k         <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (op_start) begin
            r_count     <= job_count;
            r_rd_addr   <= src_addr;
            r_wbase     <= dst_addr;
            r_jobs_done <= '0;
            r_ovf       <= 1'b0;
            if (job_count == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_RD_REQ;
              r_req   <= 1'b1;
              r_wr    <= 1'b0;
              r_addr  <= src_addr;
            end
          end
        end
        ST_RD_REQ: if (M_grant) r_state <= ST_RD_DATA;
        ST_RD_DATA: begin
          r_state <= ST_CALC;
          r_req   <= 1'b0;
        end
        ST_CALC: begin
          if (!w_mul_busy) begin
            r_state <= ST_WR;
            r_k     <= '0;
            r_req   <= 1'b1;
            r_wr    <= 1'b1;
            r_addr  <= r_wbase;
            r_dout  <= word_sel(w_acc, '0);
          end else begin
            r_ovf <= r_ovf | w_mul_ovf;
          end
        end
        // Address and data are held while the grant is withdrawn.
        ST_WR: begin
          if (M_grant) begin
            if (r_k == K_W'(WORDS - 1)) begin
              r_result    <= w_acc;
              r_jobs_done <= r_jobs_done + CNT_W'(1);
              r_state     <= ST_NEXT;
              r_req       <= 1'b0;
              r_wr        <= 1'b0;
            end else begin
              r_k    <= r_k + K_W'(1);
              r_addr <= r_addr + ADDR_W'(1);
              r_dout <= word_sel(w_acc, r_k + K_W'(1));
            end
          end
        end
        ST_NEXT: begin
          if (r_jobs_done == r_count) begin
            r_state <= ST_DONE;
          end else begin
            r_state   <= ST_RD_REQ;
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
            r_wbase   <= r_wbase + ADDR_W'(WORDS);
            r_req     <= 1'b1;
            r_wr      <= 1'b0;
            r_addr    <= r_rd_addr + ADDR_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign M_req     = r_req;
  assign M_wr      = r_wr;
  assign M_address = r_addr;
  assign M_dout    = r_dout;
  assign result    = r_result;
  assign overflow  = r_ovf;
  assign jobs_done = r_jobs_done;
  assign state     = r_state;
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);

endmodule
